// File: rtl/param_fifo_pkg.sv
// rtl/param_fifo_pkg.sv - shared state encoding and width helpers for param_fifo
package fifo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    WR_RD,
    WR_RD_FULL,
    WR_RD_EMPTY,
    WR_ERR,
    RD_ERR
  } fifo_state_e;

  // PTR_W for a given depth; the occupancy counter needs one extra bit to hold DEPTH itself.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/param_fifo_if.sv
// rtl/param_fifo_if.sv - producer/consumer bundle for param_fifo
interface param_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
);
  localparam int CNT_W = fifo_pkg::count_width(DEPTH);

  logic                  wr_en;
  logic                  rd_en;
  logic                  flush;
  logic [DATA_WIDTH-1:0] d_in;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  wr_ack;
  logic                  wr_err;
  logic                  rd_ack;
  logic                  rd_err;
  logic [CNT_W-1:0]      data_count;

  modport master (
    output wr_en, rd_en, flush, d_in,
    input  d_out, full, empty, almost_full, almost_empty,
    input  wr_ack, wr_err, rd_ack, rd_err, data_count
  );

  modport slave (
    input  wr_en, rd_en, flush, d_in,
    output d_out, full, empty, almost_full, almost_empty,
    output wr_ack, wr_err, rd_ack, rd_err, data_count
  );

endinterface

// File: rtl/param_fifo_mem.sv
// rtl/param_fifo_mem.sv - DEPTH x DATA_WIDTH register file, sync write, async read, no reset
module fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int PTR_W      = fifo_pkg::ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PTR_W-1:0]      wAddr,
  input  logic [DATA_WIDTH-1:0] wData,
  input  logic [PTR_W-1:0]      rAddr,
  output logic [DATA_WIDTH-1:0] rData
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wAddr] <= wData;
    end
  end

  assign rData = mem_q[rAddr];

endmodule

// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - parametrised synchronous FIFO with registered ack/err handshake and flush
// Optional: PARAM_FIFO_HOLD_DOUT_EN keeps d_out at the last read word instead of returning to 0.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  param_fifo_if.slave   fifo_if
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = count_width(DEPTH);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  fifo_state_e           state_q, state_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  logic                  is_full, is_empty;
  logic                  do_wr, do_rd;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign is_full  = (count_q == CNT_FULL);
  assign is_empty = (count_q == '0);

  // Classify the sampled requests against the pre-edge occupancy; flush wins over both.
  always_comb begin
    state_d = IDLE;
    case ({fifo_if.wr_en, fifo_if.rd_en})
      2'b10:   state_d = is_full  ? WR_ERR : WRITE;
      2'b01:   state_d = is_empty ? RD_ERR : READ;
      2'b11: begin
        if (is_full) begin
          state_d = WR_RD_FULL;
        end else if (is_empty) begin
          state_d = WR_RD_EMPTY;
        end else begin
          state_d = WR_RD;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fifo_if.flush) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    do_wr = (state_d == WRITE) || (state_d == WR_RD) ||
            (state_d == WR_RD_FULL) || (state_d == WR_RD_EMPTY);
    do_rd = (state_d == READ) || (state_d == WR_RD) || (state_d == WR_RD_FULL);
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
`ifdef PARAM_FIFO_HOLD_DOUT_EN
    dout_d  = dout_q;
`else
    dout_d  = '0;
`endif
    if (fifo_if.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      dout_d  = '0;
    end else begin
      if (do_wr) begin
        tail_d = tail_q + PTR_ONE;
      end
      if (do_rd) begin
        head_d = head_q + PTR_ONE;
        dout_d = mem_rdata;
      end
      case (state_d)
        WRITE, WR_RD_EMPTY: count_d = count_q + CNT_ONE;
        READ:               count_d = count_q - CNT_ONE;
        default:            count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (reset_n && do_wr),
    .wAddr (tail_q),
    .wData (fifo_if.d_in),
    .rAddr (head_q),
    .rData (mem_rdata)
  );

  // The state register holds last edge's outcome, so the handshake flags are single-flop decodes of it.
  assign fifo_if.wr_ack = (state_q == WRITE) || (state_q == WR_RD) ||
                          (state_q == WR_RD_FULL) || (state_q == WR_RD_EMPTY);
  assign fifo_if.wr_err = (state_q == WR_ERR);
  assign fifo_if.rd_ack = (state_q == READ) || (state_q == WR_RD) || (state_q == WR_RD_FULL);
  assign fifo_if.rd_err = (state_q == RD_ERR) || (state_q == WR_RD_EMPTY);

  assign fifo_if.d_out        = dout_q;
  assign fifo_if.data_count   = count_q;
  assign fifo_if.full         = is_full;
  assign fifo_if.empty        = is_empty;
  assign fifo_if.almost_full  = (int'(count_q) >= AF_LEVEL);
  assign fifo_if.almost_empty = (int'(count_q) <= AE_LEVEL);

endmodule
